mm_job_scheduler: RTL and testbench
===================================

# mm_job_scheduler

Job scheduler that sequences the Montgomery multiplier core on behalf of the processor. The processor pushes operand base addresses into a small job FIFO. The scheduler pops them one at a time, pulses the core's start, waits for completion, and reports each result with a cycle count and an interrupt. A watchdog aborts and resets a hung core. It sits between the processor-facing register/AXI glue and the multiplier top wrapper.

## Interface
Parameters:
- FIFO_DEPTH, 4: job FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 32: width of a job base address (word index, before any byte shift).
- CNT_WIDTH, 16: width of the cycle counter and the completed-job counter.
- TIMEOUT_CYCLES, 65535: RUN cycles before abort; must be < 2^CNT_WIDTH.

Ports:
- clock_i, in, 1: sole clock.
- reset_i, in, 1: asynchronous, active-high reset.
- job_valid_i, in, 1: processor offers a job.
- job_base_i, in, ADDR_WIDTH: operand base address of the offered job.
- job_ready_o, out, 1: FIFO not full.
- core_start_o, out, 1: one-cycle start pulse to the core.
- core_base_o, out, ADDR_WIDTH: base address of the job in flight; held from pop to the next pop.
- core_reset_o, out, 1: core reset, asserted only during ABORT.
- core_done_i, in, 1: core completion; pulse or level, only the rising edge is used.
- result_valid_o, out, 1: one-cycle pulse, job retired.
- result_base_o, out, ADDR_WIDTH: base address of the retired job.
- result_cycles_o, out, CNT_WIDTH: RUN cycles of the retired job.
- result_err_o, out, 1: retired job was aborted (qualified by result_valid_o).
- irq_o, out, 1: sticky interrupt.
- irq_ack_i, in, 1: clears irq_o.
- busy_o, out, 1: state ≠ IDLE or FIFO non-empty.
- jobs_done_o, out, CNT_WIDTH: completed-job count, wraps modulo 2^CNT_WIDTH.

## Operation
- FIFO push on job_valid_i & job_ready_o. Pushes while full are impossible because ready is low. A push and a pop in the same cycle are both honoured.
- Done edge: done_q is the registered copy of core_done_i, reset 0. done_edge = core_done_i & ~done_q.

FSM states and transitions:
- IDLE: if the FIFO is non-empty, pop, load core_base_o, go to LAUNCH. Otherwise stay.
- LAUNCH: core_start_o=1; clear the cycle counter; go to RUN.
- RUN: increment the cycle counter every cycle.
  - On done_edge, go to RETIRE with err=0.
  - Else, if the counter equals TIMEOUT_CYCLES-1, go to ABORT.
  - If both happen in the same cycle, done wins.
- ABORT: core_reset_o=1 for exactly 2 cycles (2-bit sub-counter), then go to RETIRE with err=1.
- RETIRE: for one cycle, result_valid_o=1 and result_base_o=core_base_o; set irq_o; go to IDLE.
  - result_cycles_o latches the counter.
  - jobs_done_o increments only when err=0.
- irq_o is set in RETIRE and cleared by irq_ack_i. If set and ack occur in the same cycle, set wins.
- The cycle counter saturates at 2^CNT_WIDTH-1 and never wraps.

Reset values, all outputs: 0. FIFO empty, state IDLE, done_q=0. job_ready_o reads 1 one cycle after reset release. Reset mid-job discards the in-flight and queued jobs and emits no result.

## Timing
- Handshake in cycle n → pop at the end of n+1 → core_start_o high in cycle n+2 (exactly one cycle).
- All outputs are registered. There is no combinational path from inputs to outputs except job_ready_o, which is derived from the registered FIFO count.
- done_edge sampled in cycle m → result_valid_o high in m+1 → IDLE in m+2 → earliest next core_start_o in m+3 if the FIFO is non-empty.
- result_cycles_o = number of RUN cycles up to and including the done_edge cycle.
- Abort path: last RUN cycle t → core_reset_o high in t+1 and t+2 → result_valid_o in t+3.
- A done edge arriving outside RUN is ignored.

## Structure
- Package mm_sched_pkg holds:
  - state_t enum: IDLE, LAUNCH, RUN, ABORT, RETIRE.
  - ABORT_RESET_CYCLES = 2.
  - a clog2-based pointer-width helper.
- Sub-module mm_job_fifo: synchronous FIFO, ADDR_WIDTH × FIFO_DEPTH, registered count, full/empty flags, async active-high reset.
- Top: FSM, counters, done-edge register, irq logic.

## Test plan
- Single job: push base 0x40, core_done_i pulses 30 cycles after start → start in cycle n+2, result_valid with base 0x40, result_cycles=30, err=0, jobs_done=1, irq_o=1 until ack.
- Back-to-back: push 0x10, 0x20, 0x30, 0x40, 0x50 without gaps.
  - Required: job_ready_o drops after the 4th queued entry and the 5th waits.
  - Required: results come out in order.
  - Required: starts are ≥3 cycles after the previous done edge.
- Timeout: TIMEOUT_CYCLES=8, done never asserts → core_reset_o high for 2 cycles, result_valid with err=1 and result_cycles=8, jobs_done unchanged.
- Done level held high across two jobs → the second job does not retire until done falls and rises again.
- Simultaneous events:
  - done edge on the timeout cycle → err=0.
  - irq_ack_i in the RETIRE cycle → irq_o stays 1.
- Reset asserted mid-RUN with 2 jobs queued → all outputs 0 asynchronously, FIFO empty, no result_valid after release.

Source files
------------

// File: rtl/mm_sched_pkg.sv
// Shared types and constants for the Montgomery-multiplier job scheduler.
package mm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    ABORT,
    RETIRE
  } state_t;

  localparam int unsigned ABORT_RESET_CYCLES = 2;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mm_job_fifo.sv
// Job-address FIFO: registered occupancy count drives the full/empty flags.
module mm_job_fifo
  import mm_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // Depth is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mm_job_scheduler.sv
// Sequences queued jobs onto the Montgomery core: launch, wait for done edge
// or watchdog abort, then retire with cycle count and sticky interrupt.
module mm_job_scheduler
  import mm_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  job_valid_i,
  input  logic [ADDR_WIDTH-1:0] job_base_i,
  output logic                  job_ready_o,
  output logic                  core_start_o,
  output logic [ADDR_WIDTH-1:0] core_base_o,
  output logic                  core_reset_o,
  input  logic                  core_done_i,
  output logic                  result_valid_o,
  output logic [ADDR_WIDTH-1:0] result_base_o,
  output logic [CNT_WIDTH-1:0]  result_cycles_o,
  output logic                  result_err_o,
  output logic                  irq_o,
  input  logic                  irq_ack_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  jobs_done_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]           ABORT_LAST   = 2'(ABORT_RESET_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_ready_en;
  logic                  r_done_q;
  logic                  w_done_edge;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_fifo_data;
  logic [ADDR_WIDTH-1:0] r_core_base;
  logic [ADDR_WIDTH-1:0] r_result_base;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic [CNT_WIDTH-1:0]  w_cycles_next;
  logic [CNT_WIDTH-1:0]  r_result_cycles;
  logic [CNT_WIDTH-1:0]  r_jobs_done;
  logic [1:0]            r_abort_cnt;
  logic                  r_result_err;
  logic                  r_irq;

  // Ready is held low until the first clock after reset release.
  assign job_ready_o     = r_ready_en & ~w_full;
  assign w_push          = job_valid_i & job_ready_o;
  assign w_pop           = (r_state == IDLE) & ~w_empty;
  assign w_done_edge     = core_done_i & ~r_done_q;
  assign core_base_o     = r_core_base;
  assign result_base_o   = r_result_base;
  assign result_cycles_o = r_result_cycles;
  assign result_err_o    = r_result_err;
  assign irq_o           = r_irq;
  assign jobs_done_o     = r_jobs_done;
  assign busy_o          = (r_state != IDLE) | ~w_empty;

  mm_job_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .i_clk  (clock_i),
    .i_rst  (reset_i),
    .i_push (w_push),
    .i_data (job_base_i),
    .i_pop  (w_pop),
    .o_data (w_fifo_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_next         = r_state;
    w_cycles_next  = r_cycles;
    core_start_o   = 1'b0;
    core_reset_o   = 1'b0;
    result_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = LAUNCH;
      end
      LAUNCH: begin
        core_start_o  = 1'b1;
        w_cycles_next = '0;
        w_next        = RUN;
      end
      RUN: begin
        if (r_cycles != '1) w_cycles_next = r_cycles + 1'b1;
        // Done has priority over the watchdog on the same cycle.
        if (w_done_edge)                     w_next = RETIRE;
        else if (r_cycles == TIMEOUT_LAST)   w_next = ABORT;
      end
      ABORT: begin
        core_reset_o = 1'b1;
        if (r_abort_cnt == ABORT_LAST) w_next = RETIRE;
      end
      RETIRE: begin
        result_valid_o = 1'b1;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= IDLE;
      r_ready_en      <= 1'b0;
      r_done_q        <= 1'b0;
      r_core_base     <= '0;
      r_result_base   <= '0;
      r_cycles        <= '0;
      r_result_cycles <= '0;
      r_jobs_done     <= '0;
      r_abort_cnt     <= '0;
      r_result_err    <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready_en  <= 1'b1;
      r_done_q    <= core_done_i;
      r_cycles    <= w_cycles_next;
      r_abort_cnt <= (r_state == ABORT) ? r_abort_cnt + 1'b1 : '0;
      if (w_pop) r_core_base <= w_fifo_data;
      if (w_next == RETIRE) begin
        r_result_base   <= r_core_base;
        r_result_cycles <= w_cycles_next;
        r_result_err    <= (r_state == ABORT);
      end
      if (r_state == RETIRE)  r_irq <= 1'b1;
      else if (irq_ack_i)     r_irq <= 1'b0;
      if (r_state == RETIRE && !r_result_err) r_jobs_done <= r_jobs_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Scoreboard bench for mm_job_scheduler with a scripted core responder.
module tb_mm_job_scheduler;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 40;

  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] cyc;
    logic          err;
  } exp_t;

  logic          clk;
  logic          reset_i;
  logic          job_valid;
  logic [AW-1:0] job_base;
  logic          job_ready_o;
  logic          core_start_o;
  logic [AW-1:0] core_base_o;
  logic          core_reset_o;
  logic          core_done;
  logic          man_done;
  logic          rsp_done;
  logic          result_valid_o;
  logic [AW-1:0] result_base_o;
  logic [CW-1:0] result_cycles_o;
  logic          result_err_o;
  logic          irq_o;
  logic          irq_ack;
  logic          busy_o;
  logic [CW-1:0] jobs_done_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done = 0;
  logic have_done = 1'b0;
  logic gap_chk = 1'b0;
  exp_t exp_q[$];
  int   dq[$];

  assign core_done = man_done | rsp_done;

  mm_job_scheduler #(
    .FIFO_DEPTH(4),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .job_valid_i    (job_valid),
    .job_base_i     (job_base),
    .job_ready_o    (job_ready_o),
    .core_start_o   (core_start_o),
    .core_base_o    (core_base_o),
    .core_reset_o   (core_reset_o),
    .core_done_i    (core_done),
    .result_valid_o (result_valid_o),
    .result_base_o  (result_base_o),
    .result_cycles_o(result_cycles_o),
    .result_err_o   (result_err_o),
    .irq_o          (irq_o),
    .irq_ack_i      (irq_ack),
    .busy_o         (busy_o),
    .jobs_done_o    (jobs_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every retired job must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_i && result_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(result_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_base", 64'(result_base_o), 64'(e.base));
        chk("res_cycles", 64'(result_cycles_o), 64'(e.cyc));
        chk("res_err", 64'(result_err_o), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_i && core_start_o && gap_chk && have_done)
      chk("start_gap", 64'(cyc - last_done), 64'd3);
  end

  // Core model: delay d>0 raises done in RUN cycle d; d==0 never answers.
  initial begin
    int d;
    rsp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_i && core_start_o && dq.size() > 0) begin
        d = dq.pop_front();
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 rsp_done = 1'b1;
          last_done = cyc;
          have_done = 1'b1;
          @(posedge clk);
          #1 rsp_done = 1'b0;
        end
      end
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic push(input logic [AW-1:0] base, input int delay, input int exp_cyc,
                      input logic exp_err, output int waited, output int at);
    int i;
    exp_t e;
    i = 0;
    job_valid = 1'b1;
    job_base  = base;
    @(negedge clk);
    while (!job_ready_o && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!job_ready_o) chk("push_accept", 64'(job_ready_o), 64'd1);
    e.base = base;
    e.cyc  = CW'(exp_cyc);
    e.err  = exp_err;
    exp_q.push_back(e);
    if (delay >= 0) dq.push_back(delay);
    waited = i;
    at = cyc;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_for(input int sel, input string name, output int at);
    int   i;
    logic s;
    i = 0;
    do begin
      @(negedge clk);
      i++;
      s = (sel == 0) ? core_start_o : (sel == 1) ? result_valid_o : core_reset_o;
    end while (!s && i < 200);
    chk(name, 64'(s), 64'd1);
    at = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while ((busy_o || exp_q.size() != 0) && i < budget);
    chk("idle_reached", 64'(busy_o), 64'd0);
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({job_ready_o, core_start_o, core_reset_o, result_valid_o,
                             result_err_o, irq_o, busy_o}), 64'd0);
    chk({tag, "_core_base"}, 64'(core_base_o), 64'd0);
    chk({tag, "_result_base"}, 64'(result_base_o), 64'd0);
    chk({tag, "_result_cycles"}, 64'(result_cycles_o), 64'd0);
    chk({tag, "_jobs_done"}, 64'(jobs_done_o), 64'd0);
  endtask

  initial begin
    int w, n, l, l2, r, a;
    reset_i   = 1'b1;
    job_valid = 1'b0;
    job_base  = '0;
    irq_ack   = 1'b0;
    man_done  = 1'b0;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 64'(job_ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Single job, done 30 cycles into RUN.
    push(32'h40, 30, 30, 1'b0, w, n);
    wait_for(0, "start_seen", l);
    chk("start_latency", 64'(l - n), 64'd2);
    chk("core_base", 64'(core_base_o), 64'h40);
    @(negedge clk);
    chk("start_one_cycle", 64'(core_start_o), 64'd0);
    wait_for(1, "result_seen", r);
    chk("done_to_result", 64'(r - l), 64'd31);
    @(negedge clk);
    chk("irq_set", 64'(irq_o), 64'd1);
    chk("jobs_done_1", 64'(jobs_done_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("irq_sticky", 64'(irq_o), 64'd1);
    @(posedge clk);
    #1 irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(negedge clk);
    chk("irq_cleared", 64'(irq_o), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back while a job runs: FIFO fills, fifth offer stalls.
    push(32'h08, 20, 20, 1'b0, w, n);
    wait_for(0, "start_08", l);
    @(posedge clk);
    #1 gap_chk = 1'b1;
    push(32'h10, 4, 4, 1'b0, w, n);
    push(32'h20, 4, 4, 1'b0, w, n);
    push(32'h30, 4, 4, 1'b0, w, n);
    push(32'h40, 4, 4, 1'b0, w, n);
    push(32'h50, 4, 4, 1'b0, w, n);
    chk("fifth_waits", 64'(w > 0), 64'd1);
    @(negedge clk);
    chk("ready_full", 64'(job_ready_o), 64'd0);
    wait_idle(500);
    gap_chk = 1'b0;
    chk("jobs_done_7", 64'(jobs_done_o), 64'd7);

    // Watchdog abort.
    push(32'h77, 0, TO, 1'b1, w, n);
    wait_for(0, "start_77", l);
    wait_for(2, "abort_seen", a);
    chk("abort_time", 64'(a - l), 64'(TO + 1));
    @(negedge clk);
    chk("abort_2nd", 64'(core_reset_o), 64'd1);
    @(negedge clk);
    chk("abort_end", 64'(core_reset_o), 64'd0);
    chk("abort_result", 64'(result_valid_o), 64'd1);
    @(negedge clk);
    chk("jobs_after_abort", 64'(jobs_done_o), 64'd7);
    wait_idle(100);

    // Done edge on the timeout cycle, ack during RETIRE.
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(negedge clk);
    chk("irq_pre", 64'(irq_o), 64'd0);
    @(posedge clk);
    #1;
    push(32'h99, TO, TO, 1'b0, w, n);
    wait_for(0, "start_99", l);
    repeat (TO + 1) @(posedge clk);
    #1 irq_ack = 1'b1;
    @(negedge clk);
    chk("retire_align", 64'(result_valid_o), 64'd1);
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(negedge clk);
    chk("irq_set_wins", 64'(irq_o), 64'd1);
    chk("jobs_done_8", 64'(jobs_done_o), 64'd8);
    wait_idle(100);

    // Done edge while idle is ignored.
    man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_done_ignored", 64'(jobs_done_o), 64'd8);
    @(posedge clk);
    #1;

    // Done held high across two jobs: second needs a fresh rising edge.
    push(32'hA1, -1, 3, 1'b0, w, n);
    push(32'hA2, -1, 6, 1'b0, w, n);
    wait_for(0, "start_a1", l);
    repeat (3) @(posedge clk);
    #1 man_done = 1'b1;
    wait_for(0, "start_a2", l2);
    chk("a2_start", 64'(l2 - l), 64'd6);
    repeat (5) @(posedge clk);
    #1 man_done = 1'b0;
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    wait_idle(100);
    chk("jobs_done_10", 64'(jobs_done_o), 64'd10);

    // Asynchronous reset mid-RUN with two jobs queued.
    push(32'hB1, 0, TO, 1'b1, w, n);
    push(32'hB2, 0, TO, 1'b1, w, n);
    push(32'hB3, 0, TO, 1'b1, w, n);
    wait_for(0, "start_b1", l);
    repeat (5) @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk_zero("midrun_reset");
    exp_q.delete();
    dq.delete();
    @(posedge clk);
    #1 reset_i = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_reset_busy", 64'(busy_o), 64'd0);
    chk("post_reset_ready", 64'(job_ready_o), 64'd1);
    chk("post_reset_jobs", 64'(jobs_done_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
